seg_to_bcd_encoder: RTL and testbench

//  Reverse of the hex display decoder: watches one active-low 7-segment bus and recovers the digit it shows.

---
 rtl/seg_to_bcd_encoder.sv | 168 ++++++++++++++++
 tb/tb_seg_to_bcd_encoder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_to_bcd_encoder.sv
// Recovers the digit shown on an active-low 7-segment bus: debounce, classify, hand out over valid/ready.
// Optional SEG_ERRCNT_EN adds a saturating err_count of accepted error events.
module seg_to_bcd_encoder #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] hex_in,
    input  logic       enable,
    input  logic       ready,
    output logic       valid,
    output logic [3:0] digit_out,
    output logic       blank_out,
    output logic       error_out,
    output logic       busy
`ifdef SEG_ERRCNT_EN
    ,
    output logic [7:0] err_count
`endif
);

    localparam int unsigned SEG_W = 7;
    localparam int unsigned DIG_W = 4;
    localparam logic [SEG_W-1:0] SEG_ZERO  = 7'b1000000;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        EMIT   = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [SEG_W-1:0]   hex_q;
    logic [SEG_W-1:0]   last, last_d;
    logic [SEG_W-1:0]   cand, cand_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               valid_d;
    logic [DIG_W-1:0]   digit_d;
    logic               blank_d;
    logic               error_d;
    logic [DIG_W-1:0]   dec_digit;
    logic               dec_blank;
    logic               dec_error;

    // Classify the settled candidate pattern.
    always_comb begin
        dec_digit = 4'hF;
        dec_blank = 1'b0;
        dec_error = 1'b0;
        case (cand)
            7'b1000000: dec_digit = 4'd0;
            7'b1111001: dec_digit = 4'd1;
            7'b0100100: dec_digit = 4'd2;
            7'b0110000: dec_digit = 4'd3;
            7'b0011001: dec_digit = 4'd4;
            7'b0010010: dec_digit = 4'd5;
            7'b0000010: dec_digit = 4'd6;
            7'b1111000: dec_digit = 4'd7;
            7'b0000000: dec_digit = 4'd8;
            7'b0010000: dec_digit = 4'd9;
            SEG_BLANK: begin
                dec_digit = 4'd10;
                dec_blank = 1'b1;
            end
            default:    dec_error = 1'b1;
        endcase
    end

    // Next-state and datapath updates.
    always_comb begin
        state_d = state;
        last_d  = last;
        cand_d  = cand;
        cnt_d   = cnt;
        valid_d = valid;
        digit_d = digit_out;
        blank_d = blank_out;
        error_d = error_out;
        case (state)
            IDLE: begin
                if (enable && (hex_q != last)) begin
                    state_d = SETTLE;
                    cand_d  = hex_q;
                    cnt_d   = CNT_ONE;
                end
            end
            SETTLE: begin
                if (!enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (hex_q != cand) begin
                    // A glitch back to the last reported pattern is not a new event.
                    if (hex_q == last) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cand_d = hex_q;
                        cnt_d  = CNT_ONE;
                    end
                end else if (cnt == CNT_LAST) begin
                    state_d = EMIT;
                    valid_d = 1'b1;
                    digit_d = dec_digit;
                    blank_d = dec_blank;
                    error_d = dec_error;
                end else begin
                    cnt_d = cnt + CNT_ONE;
                end
            end
            EMIT: begin
                if (valid && ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    last_d  = cand;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_d;
            busy  <= (state_d != IDLE);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hex_q     <= SEG_ZERO;
            last      <= SEG_ZERO;
            cand      <= '0;
            cnt       <= '0;
            valid     <= 1'b0;
            digit_out <= '0;
            blank_out <= 1'b0;
            error_out <= 1'b0;
        end else begin
            hex_q     <= hex_in;
            last      <= last_d;
            cand      <= cand_d;
            cnt       <= cnt_d;
            valid     <= valid_d;
            digit_out <= digit_d;
            blank_out <= blank_d;
            error_out <= error_d;
        end
    end

`ifdef SEG_ERRCNT_EN
    // Saturating count of accepted error events.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_count <= '0;
        end else if (valid && ready && error_out && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_seg_to_bcd_encoder.sv
// Directed self-checking bench for seg_to_bcd_encoder (err_count checks only when SEG_ERRCNT_EN is defined).
module tb_seg_to_bcd_encoder;

    logic       clock;
    logic       reset;
    logic [6:0] hex_in;
    logic       enable;
    logic       ready;
    logic       valid;
    logic [3:0] digit_out;
    logic       blank_out;
    logic       error_out;
    logic       busy;
`ifdef SEG_ERRCNT_EN
    logic [7:0] err_count;
`endif

    int passed = 0;
    int total  = 0;

    seg_to_bcd_encoder dut (
        .clock     (clock),
        .reset     (reset),
        .hex_in    (hex_in),
        .enable    (enable),
        .ready     (ready),
        .valid     (valid),
        .digit_out (digit_out),
        .blank_out (blank_out),
        .error_out (error_out),
        .busy      (busy)
`ifdef SEG_ERRCNT_EN
        ,
        .err_count (err_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Advance until valid rises or the budget runs out.
    task automatic wait_valid(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (valid === 1'b1) begin
                got = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        int bad_valid;
        int bad_busy;
        reset  = 1'b0;
        hex_in = 7'b1000000;
        enable = 1'b0;
        ready  = 1'b0;
        #3;
        total++; if (valid !== 1'b0) $display("FAIL reset_valid got=%b want=0", valid); else passed++;
        total++; if (digit_out !== 4'd0) $display("FAIL reset_digit got=%0d want=0", digit_out); else passed++;
        total++; if (blank_out !== 1'b0) $display("FAIL reset_blank got=%b want=0", blank_out); else passed++;
        total++; if (error_out !== 1'b0) $display("FAIL reset_error got=%b want=0", error_out); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", busy); else passed++;
        #19;
        reset  = 1'b1;
        enable = 1'b1;
        ready  = 1'b1;
        bad_valid = 0;
        bad_busy  = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (valid !== 1'b0) bad_valid++;
            if (busy !== 1'b0) bad_busy++;
        end
        total++; if (bad_valid != 0) $display("FAIL idle_zero_valid got=%0d cycles want=0", bad_valid); else passed++;
        total++; if (bad_busy != 0) $display("FAIL idle_zero_busy got=%0d cycles want=0", bad_busy); else passed++;
    endtask

    task automatic test_latency();
        int early;
        hex_in = 7'b0100100;
        early  = 0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            if (valid !== 1'b0) early++;
        end
        total++; if (early != 0) $display("FAIL lat_early got=%0d cycles want=0", early); else passed++;
        tick();
        total++; if (valid !== 1'b1) $display("FAIL lat_valid5 got=%b want=1", valid); else passed++;
        total++; if (digit_out !== 4'd2) $display("FAIL lat_digit got=%0d want=2", digit_out); else passed++;
        total++; if (error_out !== 1'b0) $display("FAIL lat_error got=%b want=0", error_out); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL lat_busy got=%b want=1", busy); else passed++;
        tick();
        total++; if (valid !== 1'b0) $display("FAIL lat_drop got=%b want=0", valid); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL lat_idle got=%b want=0", busy); else passed++;
        total++; if (digit_out !== 4'd2) $display("FAIL lat_keep got=%0d want=2", digit_out); else passed++;
    endtask

    task automatic test_resettle();
        int events;
        logic [3:0] first_digit;
        hex_in = 7'b0010000;
        tick();
        tick();
        hex_in = 7'b0110000;
        events = 0;
        first_digit = 4'h0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (valid === 1'b1) begin
                if (events == 0) first_digit = digit_out;
                events++;
            end
        end
        total++; if (events != 1) $display("FAIL resettle_events got=%0d want=1", events); else passed++;
        total++; if (first_digit !== 4'd3) $display("FAIL resettle_digit got=%0d want=3", first_digit); else passed++;
    endtask

    task automatic test_backpressure();
        bit got;
        int held_bad;
        int extra;
        ready  = 1'b0;
        hex_in = 7'b1111111;
        wait_valid(12, got);
        total++; if (!got) $display("FAIL bp_timeout got=0 want=1"); else passed++;
        total++; if (digit_out !== 4'd10) $display("FAIL bp_digit got=%0d want=10", digit_out); else passed++;
        total++; if (blank_out !== 1'b1) $display("FAIL bp_blank got=%b want=1", blank_out); else passed++;
        total++; if (error_out !== 1'b0) $display("FAIL bp_error got=%b want=0", error_out); else passed++;
        held_bad = 0;
        for (int i = 0; i < 10; i++) begin
            hex_in = (i % 2 == 0) ? 7'b1111001 : 7'b0000000;
            tick();
            if (valid !== 1'b1 || digit_out !== 4'd10 || blank_out !== 1'b1) held_bad++;
        end
        total++; if (held_bad != 0) $display("FAIL bp_hold got=%0d bad cycles want=0", held_bad); else passed++;
        hex_in = 7'b1111111;
        ready  = 1'b1;
        tick();
        total++; if (valid !== 1'b0) $display("FAIL bp_accept got=%b want=0", valid); else passed++;
        total++; if (blank_out !== 1'b1) $display("FAIL bp_keep_blank got=%b want=1", blank_out); else passed++;
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (valid === 1'b1) extra++;
        end
        total++; if (extra != 0) $display("FAIL bp_repeat got=%0d events want=0", extra); else passed++;
    endtask

    task automatic test_error();
        bit got;
        int timeouts;
        hex_in = 7'b0101010;
        wait_valid(12, got);
        total++; if (!got) $display("FAIL err_timeout got=0 want=1"); else passed++;
        total++; if (digit_out !== 4'hF) $display("FAIL err_digit got=%h want=f", digit_out); else passed++;
        total++; if (error_out !== 1'b1) $display("FAIL err_flag got=%b want=1", error_out); else passed++;
        total++; if (blank_out !== 1'b0) $display("FAIL err_blank got=%b want=0", blank_out); else passed++;
        tick();
        total++; if (valid !== 1'b0) $display("FAIL err_accept got=%b want=0", valid); else passed++;
`ifdef SEG_ERRCNT_EN
        total++; if (err_count !== 8'd1) $display("FAIL errcnt_one got=%0d want=1", err_count); else passed++;
        timeouts = 0;
        for (int i = 0; i < 299; i++) begin
            hex_in = (i % 2 == 0) ? 7'b0101011 : 7'b0101010;
            wait_valid(12, got);
            if (!got) timeouts++;
            tick();
        end
        total++; if (timeouts != 0) $display("FAIL errcnt_timeouts got=%0d want=0", timeouts); else passed++;
        total++; if (err_count !== 8'd255) $display("FAIL errcnt_sat got=%0d want=255", err_count); else passed++;
`else
        timeouts = 0;
        total++; if (timeouts != 0) $display("FAIL err_dummy got=%0d want=0", timeouts); else passed++;
`endif
    endtask

    task automatic test_glitch_enable();
        bit got;
        int extra;
        hex_in = 7'b1111000;
        wait_valid(12, got);
        total++; if (!got || digit_out !== 4'd7) $display("FAIL gl_seed got=%0d want=7", digit_out); else passed++;
        tick();
        hex_in = 7'b0000000;
        tick();
        tick();
        hex_in = 7'b1111000;
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (valid === 1'b1) extra++;
        end
        total++; if (extra != 0) $display("FAIL gl_glitch got=%0d events want=0", extra); else passed++;
        enable = 1'b0;
        hex_in = 7'b1111001;
        extra  = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (valid === 1'b1 || busy === 1'b1) extra++;
        end
        total++; if (extra != 0) $display("FAIL en_off got=%0d active cycles want=0", extra); else passed++;
        enable = 1'b1;
        wait_valid(12, got);
        total++; if (!got || digit_out !== 4'd1) $display("FAIL en_on got=%0d want=1", digit_out); else passed++;
        tick();
        hex_in = 7'b0011001;
        tick();
        tick();
        total++; if (busy !== 1'b1) $display("FAIL en_settle got=%b want=1", busy); else passed++;
        enable = 1'b0;
        extra  = 0;
        tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            if (valid === 1'b1 || busy === 1'b1) extra++;
        end
        total++; if (extra != 0) $display("FAIL en_abandon got=%0d active cycles want=0", extra); else passed++;
        enable = 1'b1;
        wait_valid(12, got);
        total++; if (!got || digit_out !== 4'd4) $display("FAIL en_resume got=%0d want=4", digit_out); else passed++;
        tick();
    endtask

    task automatic test_async_reset();
        bit got;
        int extra;
        int edge_seen;
        ready  = 1'b0;
        hex_in = 7'b0010010;
        wait_valid(12, got);
        total++; if (!got || digit_out !== 4'd5) $display("FAIL ar_event got=%0d want=5", digit_out); else passed++;
        #2;
        reset = 1'b0;
        #1;
        total++; if (valid !== 1'b0) $display("FAIL ar_valid got=%b want=0", valid); else passed++;
        total++; if (digit_out !== 4'd0) $display("FAIL ar_digit got=%0d want=0", digit_out); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL ar_busy got=%b want=0", busy); else passed++;
`ifdef SEG_ERRCNT_EN
        total++; if (err_count !== 8'd0) $display("FAIL ar_errcnt got=%0d want=0", err_count); else passed++;
`endif
        hex_in = 7'b1000000;
        #2;
        reset = 1'b1;
        ready = 1'b1;
        extra = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (valid === 1'b1) extra++;
        end
        total++; if (extra != 0) $display("FAIL ar_last_zero got=%0d events want=0", extra); else passed++;
        hex_in = 7'b0000010;
        edge_seen = 0;
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (valid === 1'b1 && edge_seen == 0) edge_seen = e;
        end
        total++; if (edge_seen != 5) $display("FAIL ar_latency got=%0d want=5", edge_seen); else passed++;
        total++; if (digit_out !== 4'd6) $display("FAIL ar_digit6 got=%0d want=6", digit_out); else passed++;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_resettle();
        test_backpressure();
        test_error();
        test_glitch_enable();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
